// File: rtl/testio_arb.sv
// testio_arb: round-robin arbiter and single-outstanding transaction sequencer
// that shares one testio bridge port among N_REQ requesters and routes each
// response back to the requester that issued it.
// Optional feature macro: TESTIO_ARB_TIMEOUT_EN. When it is defined, a
// transaction the bridge never answers is ended after TMO_CYC cycles with a
// synthetic 32'hDEAD_BEEF response.
module testio_arb #(
    parameter int N_REQ   = 4,
    parameter int GID_W   = 2,
    parameter int TMO_CYC = 4096
) (
    input  logic                 ti_clk_i,
    input  logic                 ti_rstn_i,
    input  logic [N_REQ-1:0]     up_req_valid,
    output logic [N_REQ-1:0]     up_req_ready,
    input  logic [N_REQ*87-1:0]  up_req,
    output logic [N_REQ-1:0]     up_resp_valid,
    input  logic [N_REQ-1:0]     up_resp_ready,
    output logic [50:0]          up_resp,
    output logic                 dn_req_valid,
    input  logic                 dn_req_ready,
    output logic [86:0]          dn_req,
    input  logic                 dn_resp_valid,
    output logic                 dn_resp_ready,
    input  logic [50:0]          dn_resp,
    output logic                 busy_o,
    output logic [GID_W-1:0]     gnt_id_o,
    output logic                 tmo_o,
    output logic                 stray_o
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_WAIT        = 2'd2
`ifdef TESTIO_ARB_TIMEOUT_EN
        ,S_DELIVER_ERR = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [GID_W-1:0] last_gnt_q;
    logic [GID_W-1:0] gnt_q;
    logic [86:0]      req_q;

    logic             found;
    logic [GID_W-1:0] pick;
    logic [86:0]      sel_req;
    logic             grant;
    logic             done;
    logic             tmo_hit;

    // Round-robin search: first valid requester upward from last_gnt+1, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_gnt_q) + k) % N_REQ;
            if (!found && up_req_valid[idx[GID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[GID_W-1:0];
            end
        end
        sel_req = up_req[int'(pick)*87 +: 87];
    end

`ifdef TESTIO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TMO_CYC));

    // Transaction age: cleared on the grant, saturates at the limit while in flight.
    always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
        if (!ti_rstn_i) begin
            tmo_cnt_q <= '0;
        end else if (grant) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == S_ISSUE || state_q == S_WAIT) && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and handshake decode.
    always_comb begin
        state_d       = state_q;
        up_req_ready  = '0;
        up_resp_valid = '0;
        up_resp       = dn_resp;
        dn_req_valid  = 1'b0;
        dn_resp_ready = 1'b0;
        stray_o       = 1'b0;
        tmo_o         = 1'b0;
        grant         = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                dn_resp_ready = 1'b1;
                stray_o       = dn_resp_valid;
                if (found) begin
                    up_req_ready[pick] = 1'b1;
                    grant              = 1'b1;
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dn_req_valid = 1'b1;
                if (dn_req_ready) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
`ifdef TESTIO_ARB_TIMEOUT_EN
                    tmo_o   = 1'b1;
                    state_d = S_DELIVER_ERR;
`endif
                end
            end
            S_WAIT: begin
                up_resp_valid[gnt_q] = dn_resp_valid;
                dn_resp_ready        = up_resp_ready[gnt_q];
                if (dn_resp_valid && up_resp_ready[gnt_q]) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
`ifdef TESTIO_ARB_TIMEOUT_EN
                    tmo_o   = 1'b1;
                    state_d = S_DELIVER_ERR;
`endif
                end
            end
`ifdef TESTIO_ARB_TIMEOUT_EN
            S_DELIVER_ERR: begin
                up_resp_valid[gnt_q] = 1'b1;
                up_resp              = {req_q[86:84], req_q[83:68], 32'hDEAD_BEEF};
                // Late bridge responses are drained silently here.
                dn_resp_ready        = 1'b1;
                if (up_resp_ready[gnt_q]) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant bookkeeping and the captured request.
    always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
        if (!ti_rstn_i) begin
            state_q    <= S_IDLE;
            last_gnt_q <= GID_W'(N_REQ - 1);
            gnt_q      <= '0;
            // NOTE: req_q is a plain register (not a memory), so it is reset to keep dn_req defined.
            req_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            if (grant) begin
                gnt_q <= pick;
                req_q <= sel_req;
            end
            if (done) begin
                last_gnt_q <= gnt_q;
            end
        end
    end

    assign dn_req   = req_q;
    assign busy_o   = (state_q != S_IDLE);
    assign gnt_id_o = gnt_q;

endmodule

// File: tb/tb_testio_arb.sv
// Self-checking bench for testio_arb: directed stimulus pushes expected grants
// and responses into queues; a negedge monitor pops and compares them.
module tb_testio_arb;

    localparam int N_REQ   = 4;
    localparam int GID_W   = 2;
    localparam int TMO_CYC = 16;
`ifdef TESTIO_ARB_TIMEOUT_EN
    localparam int T1_LAT = 8;
`else
    localparam int T1_LAT = 50;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_REQ-1:0]    up_req_valid;
    logic [N_REQ-1:0]    up_req_ready;
    logic [N_REQ*87-1:0] up_req;
    logic [N_REQ-1:0]    up_resp_valid;
    logic [N_REQ-1:0]    up_resp_ready;
    logic [50:0]         up_resp;
    logic                dn_req_valid;
    logic                dn_req_ready;
    logic [86:0]         dn_req;
    logic                dn_resp_valid;
    logic                dn_resp_ready;
    logic [50:0]         dn_resp;
    logic                busy;
    logic [GID_W-1:0]    gnt_id;
    logic                tmo;
    logic                stray;

    always #5 clk = ~clk;

    testio_arb #(.N_REQ(N_REQ), .GID_W(GID_W), .TMO_CYC(TMO_CYC)) dut (
        .ti_clk_i      (clk),
        .ti_rstn_i     (rst_n),
        .up_req_valid  (up_req_valid),
        .up_req_ready  (up_req_ready),
        .up_req        (up_req),
        .up_resp_valid (up_resp_valid),
        .up_resp_ready (up_resp_ready),
        .up_resp       (up_resp),
        .dn_req_valid  (dn_req_valid),
        .dn_req_ready  (dn_req_ready),
        .dn_req        (dn_req),
        .dn_resp_valid (dn_resp_valid),
        .dn_resp_ready (dn_resp_ready),
        .dn_resp       (dn_resp),
        .busy_o        (busy),
        .gnt_id_o      (gnt_id),
        .tmo_o         (tmo),
        .stray_o       (stray)
    );

    // Requests: {type, id, addr, strobe, wdata}
    localparam logic [86:0] R0 = {3'd0, 16'h1000, 32'h0000_0100, 4'hF, 32'h0};
    localparam logic [86:0] R1 = {3'd0, 16'h1001, 32'h0000_0104, 4'hF, 32'h0};
    localparam logic [86:0] R2 = {3'd0, 16'h1002, 32'h0000_0108, 4'hF, 32'h0};
    localparam logic [86:0] R3 = {3'd0, 16'h1003, 32'h0000_010C, 4'hF, 32'h0};
    localparam logic [86:0] W2 = {3'd1, 16'h2002, 32'h0000_0200, 4'hF, 32'hCAFE_0002};

    typedef struct {
        int          who;
        logic [50:0] resp;
    } exp_resp_t;

    int        exp_gnt[$];
    exp_resp_t exp_resp[$];
    int        n_vec  = 0;
    int        n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [86:0] v);
        up_req[i*87 +: 87] = v;
    endtask

    // Monitor: every grant and every upstream response handshake is compared
    // against the queues filled by the stimulus.
    int        mon_g;
    exp_resp_t mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (up_req_ready != '0) begin
                check("gnt_onehot", 128'($countones(up_req_ready)), 128'd1);
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", 128'(up_req_ready), 128'd0);
                end else begin
                    mon_g = exp_gnt.pop_front();
                    check("gnt_order", 128'(up_req_ready), 128'(1 << mon_g));
                end
            end
            if ((up_resp_valid & up_resp_ready) != '0) begin
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", 128'(up_resp_valid), 128'd0);
                end else begin
                    mon_r = exp_resp.pop_front();
                    check("resp_target", 128'(up_resp_valid), 128'(1 << mon_r.who));
                    check("resp_data", 128'(up_resp), 128'(mon_r.resp));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        up_req_valid  = '0;
        up_resp_ready = '1;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp       = '0;
        @(negedge clk);
        check("rst_up_req_ready", 128'(up_req_ready), 128'd0);
        check("rst_up_resp_valid", 128'(up_resp_valid), 128'd0);
        check("rst_dn_req_valid", 128'(dn_req_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_tmo", 128'(tmo), 128'd0);
        check("rst_stray", 128'(stray), 128'd0);
        check("rst_gnt_id", 128'(gnt_id), 128'd0);
        check("rst_dn_req", 128'(dn_req), 128'd0);
        check("rst_dn_resp_ready", 128'(dn_resp_ready), 128'd1);
        tick();
        rst_n = 1'b1;
    endtask

    // Bridge side of one transaction: hold dn_req_ready low for 'hold' cycles,
    // accept, answer 'lat' cycles later, with 'bp' cycles of upstream backpressure.
    task automatic serve(input int hold, input int lat, input logic [31:0] data, input int bp);
        logic [86:0] cap;
        int          g;
        int          n;
        n = 0;
        @(negedge clk);
        while (!dn_req_valid && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!dn_req_valid) begin
            check("dn_req_valid_wait", 128'(dn_req_valid), 128'd1);
            return;
        end
        cap = dn_req;
        g   = int'(gnt_id);
        for (int i = 0; i < hold; i++) begin
            check("dn_req_stable", 128'(dn_req), 128'(cap));
            check("no_grant_in_flight", 128'(up_req_ready), 128'd0);
            tick();
            @(negedge clk);
        end
        check("dn_req_stable", 128'(dn_req), 128'(cap));
        tick();
        dn_req_ready = 1'b1;
        @(negedge clk);
        check("dn_req_valid_hs", 128'(dn_req_valid), 128'd1);
        tick();
        dn_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        if (bp > 0) up_resp_ready[g] = 1'b0;
        dn_resp_valid = 1'b1;
        dn_resp       = {3'd2, cap[83:68], data};
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_dn_resp_ready", 128'(dn_resp_ready), 128'd0);
            check("bp_up_resp_valid", 128'(up_resp_valid), 128'(1 << g));
            tick();
        end
        up_resp_ready[g] = 1'b1;
        @(negedge clk);
        check("hs_dn_resp_ready", 128'(dn_resp_ready), 128'd1);
        tick();
        dn_resp_valid = 1'b0;
        dn_resp       = '0;
    endtask

    initial begin
        up_req = '0;
        do_reset();

        // Single read from requester 0, answered after T1_LAT cycles.
        set_req(0, R0);
        up_req_valid = 4'b0001;
        exp_gnt.push_back(0);
        exp_resp.push_back('{0, {3'd2, 16'h1000, 32'h1234_5678}});
        @(negedge clk);
        check("t1_grant_same_cycle", 128'(up_req_ready), 128'd1);
        tick();
        up_req_valid = '0;
        @(negedge clk);
        check("t1_dn_req_valid", 128'(dn_req_valid), 128'd1);
        check("t1_dn_req", 128'(dn_req), 128'({3'd0, 16'h1000, 32'h0000_0100, 4'hF, 32'h0}));
        check("t1_gnt_id", 128'(gnt_id), 128'd0);
        check("t1_busy", 128'(busy), 128'd1);
        serve(0, T1_LAT, 32'h1234_5678, 0);
        @(negedge clk);
        check("t1_busy_after", 128'(busy), 128'd0);
        check("t1_tmo_quiet", 128'(tmo), 128'd0);
        tick();

        // All four requesters valid: grants 0,1,2,3,0.
        do_reset();
        set_req(0, R0);
        set_req(1, R1);
        set_req(2, R2);
        set_req(3, R3);
        up_req_valid = 4'hF;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        exp_gnt.push_back(3);
        exp_gnt.push_back(0);
        exp_resp.push_back('{0, {3'd2, 16'h1000, 32'hA5A5_0000}});
        exp_resp.push_back('{1, {3'd2, 16'h1001, 32'hA5A5_0000}});
        exp_resp.push_back('{2, {3'd2, 16'h1002, 32'hA5A5_0000}});
        exp_resp.push_back('{3, {3'd2, 16'h1003, 32'hA5A5_0000}});
        exp_resp.push_back('{0, {3'd2, 16'h1000, 32'hA5A5_0000}});
        for (int i = 0; i < 5; i++) serve(0, 1, 32'hA5A5_0000, 0);
        up_req_valid = '0;

        // Requester 2 writes while the bridge stalls 10 cycles; requester 0 waits.
        set_req(2, W2);
        up_req_valid = 4'b0100;
        exp_gnt.push_back(2);
        exp_gnt.push_back(0);
        exp_resp.push_back('{2, {3'd2, 16'h2002, 32'h0000_0000}});
        exp_resp.push_back('{0, {3'd2, 16'h1000, 32'h0000_0077}});
        @(negedge clk);
        tick();
        up_req_valid = 4'b0101;
        @(negedge clk);
        check("t3_dn_req", 128'(dn_req), 128'({3'd1, 16'h2002, 32'h0000_0200, 4'hF, 32'hCAFE_0002}));
        check("t3_type", 128'(dn_req[86:84]), 128'd1);
        check("t3_strobe", 128'(dn_req[35:32]), 128'hF);
        serve(10, 1, 32'h0000_0000, 0);
        serve(0, 1, 32'h0000_0077, 0);
        up_req_valid = '0;

        // Requester 1 with 5 cycles of response backpressure.
        set_req(1, R1);
        up_req_valid = 4'b0010;
        exp_gnt.push_back(1);
        exp_resp.push_back('{1, {3'd2, 16'h1001, 32'hBEEF_0001}});
        @(negedge clk);
        tick();
        up_req_valid = '0;
        serve(0, 2, 32'hBEEF_0001, 5);

        // Stray response while idle.
        dn_resp_valid = 1'b1;
        dn_resp       = {3'd2, 16'h5555, 32'h0BAD_0BAD};
        @(negedge clk);
        check("stray_pulse", 128'(stray), 128'd1);
        check("stray_dn_resp_ready", 128'(dn_resp_ready), 128'd1);
        check("stray_no_up_resp", 128'(up_resp_valid), 128'd0);
        tick();
        dn_resp_valid = 1'b0;
        dn_resp       = '0;
        @(negedge clk);
        check("stray_single", 128'(stray), 128'd0);
        check("stray_idle", 128'(busy), 128'd0);
        tick();

`ifdef TESTIO_ARB_TIMEOUT_EN
        // Bridge accepts requester 3 and never answers.
        set_req(3, R3);
        up_req_valid = 4'b1000;
        exp_gnt.push_back(3);
        exp_resp.push_back('{3, {3'd0, 16'h1003, 32'hDEAD_BEEF}});
        @(negedge clk);
        tick();
        up_req_valid = '0;
        dn_req_ready = 1'b1;
        @(negedge clk);
        check("t6_tmo_cycle0", 128'(tmo), 128'd0);
        tick();
        dn_req_ready = 1'b0;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (tmo !== 1'b0) check("t6_tmo_early", 128'(tmo), 128'd0);
            tick();
        end
        @(negedge clk);
        check("t6_tmo_cycle16", 128'(tmo), 128'd1);
        check("t6_no_resp_yet", 128'(up_resp_valid), 128'd0);
        tick();
        @(negedge clk);
        check("t6_err_valid", 128'(up_resp_valid), 128'b1000);
        check("t6_tmo_single", 128'(tmo), 128'd0);
        tick();
        set_req(0, R0);
        up_req_valid = 4'b0001;
        exp_gnt.push_back(0);
        exp_resp.push_back('{0, {3'd2, 16'h1000, 32'h0000_0042}});
        serve(0, 1, 32'h0000_0042, 0);
        up_req_valid = '0;
`endif

        repeat (3) tick();
        check("gnt_queue_drained", 128'(exp_gnt.size()), 128'd0);
        check("resp_queue_drained", 128'(exp_resp.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/testio_arb.md
# testio_arb

Round-robin arbiter and transaction sequencer that shares one testio bridge memory port among `N_REQ` requesters. It sits between the on-chip requesters (debug master, boot loader, BIST engine, etc.) and the testio bridge. It enforces one outstanding transaction at a time and routes each response back to the requester that issued it. It also recovers from transactions that the bridge silently drops, for example after an ACK/parity error.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `GID_W`, default 2: grant index width, equal to clog2(`N_REQ`).
- `TMO_CYC`, default 4096: timeout limit in cycles. Used only when `TESTIO_ARB_TIMEOUT_EN` is defined.

Ports (name, direction, width, meaning):
- `ti_clk_i`, in, 1: clock.
- `ti_rstn_i`, in, 1: reset. Asynchronous, active-low.
- `up_req_valid`, in, `N_REQ`: per-requester request valid.
- `up_req_ready`, out, `N_REQ`: per-requester accept. One-hot or zero.
- `up_req`, in, `N_REQ`*87: packed requests, requester i at bits [87i+86:87i]. Request fields: [86:84] type (3'd1 = write), [83:68] transaction id, [67:36] address, [35:32] byte strobe, [31:0] write data.
- `up_resp_valid`, out, `N_REQ`: per-requester response valid. One-hot or zero.
- `up_resp_ready`, in, `N_REQ`: per-requester response ready.
- `up_resp`, out, 51: response, shared by all requesters. Fields: [50:48] type, [47:32] transaction id, [31:0] read data.
- `dn_req_valid`, out, 1: request valid toward the testio bridge.
- `dn_req_ready`, in, 1: bridge accept.
- `dn_req`, out, 87: request toward the bridge.
- `dn_resp_valid`, in, 1: bridge response valid.
- `dn_resp_ready`, out, 1: response ready toward the bridge.
- `dn_resp`, in, 51: bridge response.
- `busy_o`, out, 1: asserted in every state except IDLE.
- `gnt_id_o`, out, `GID_W`: index of the current or last granted requester.
- `tmo_o`, out, 1: one-cycle pulse on timeout.
- `stray_o`, out, 1: one-cycle pulse when a response is dropped in IDLE.

## Operation
State machine: IDLE, ISSUE, WAIT, DELIVER_ERR.

- **IDLE**
  - If any `up_req_valid` is set, grant the first valid requester searching upward (with wrap) from `last_gnt+1`.
  - In that cycle: assert `up_req_ready[g]`, capture the request into `req_q`, set `gnt_id_o`=g, go to ISSUE.
  - `dn_resp_ready`=1. Any `dn_resp_valid` seen here is dropped and pulses `stray_o`.
- **ISSUE**
  - `dn_req_valid`=1, `dn_req`=`req_q`. `req_q` is stable until accepted.
  - On `dn_req_ready`, go to WAIT.
- **WAIT**
  - `up_resp_valid[g]`=`dn_resp_valid`, `up_resp`=`dn_resp`, `dn_resp_ready`=`up_resp_ready[g]`.
  - On the `dn_resp_valid` && `up_resp_ready[g]` handshake: `last_gnt`←g, go to IDLE.
- **DELIVER_ERR** (timeout builds only)
  - `up_resp_valid[g]`=1 and `up_resp` = {`req_q`[86:84], `req_q`[83:68], 32'hDEAD_BEEF}.
  - `dn_resp_ready`=1, draining late bridge responses without pulsing `stray_o`.
  - On `up_resp_ready[g]`: `last_gnt`←g, go to IDLE.
- Outside IDLE, no `up_req_ready` is asserted, and the requester request lines are ignored.
- `up_resp_valid` bits other than g are always 0.

## Timing
- Reset values:
  - State IDLE; `last_gnt`=`N_REQ`-1, so requester 0 wins first.
  - All `up_req_ready`, `up_resp_valid`, `dn_req_valid`, `busy_o`, `tmo_o`, `stray_o` = 0.
  - `gnt_id_o`=0, `req_q`=0.
  - `dn_resp_ready`=1, since it is combinational and reset puts the FSM in IDLE.
- Grant latency: `up_req_ready` is combinational, in the same cycle as `up_req_valid` when the FSM is in IDLE.
- Issue latency: `dn_req_valid` rises in the cycle after the grant.
- Response path: combinational pass-through in WAIT, zero added latency.
- Minimum back-to-back spacing: the next grant happens no earlier than the cycle after the response handshake.
- Reset mid-transaction: asynchronously returns to IDLE with no response delivered. Requesters must also be reset.

## Configuration
`TESTIO_ARB_TIMEOUT_EN`:
- **Defined:**
  - A `clog2(TMO_CYC+1)`-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When the counter equals `TMO_CYC` and no handshake occurs that cycle: pulse `tmo_o` and go to DELIVER_ERR.
  - If a downstream handshake coincides with the timeout cycle, the handshake wins and no timeout is raised.
- **Undefined:** the counter and the DELIVER_ERR state are absent, `tmo_o` is tied to 0, and WAIT waits indefinitely.

## Test plan
- Reset, then requester 0 issues a read to address 0x100, and the bridge returns data 0x12345678 after 50 cycles. Required: `up_req_ready[0]` in cycle 0; `dn_req_valid` in cycle 1; `up_resp_valid[0]` with data 0x12345678 and the original id; `busy_o` drops after the handshake.
- All four requesters hold valid continuously. Required: grant order 0,1,2,3,0, and no requester is granted twice before every other valid requester has been granted once.
- Requester 2 writes while the bridge holds `dn_req_ready` low for 10 cycles. Required: `dn_req` stays stable and equal to the captured write (type 1, strobe 0xF), and no other requester is granted meanwhile.
- Response backpressure: `up_resp_ready[1]`=0 for 5 cycles. Required: `dn_resp_ready`=0 for those cycles, and exactly one handshake follows.
- Timeout build with `TMO_CYC`=16 and the bridge never responding. Required: `tmo_o` pulses in cycle 16 after the request is accepted, the granted requester receives 0xDEADBEEF with its id, and the next request is granted afterward.
- Stray response while IDLE. Required: `stray_o` pulses once, `dn_resp_ready`=1, and no `up_resp_valid` is asserted.
